// File: rtl/usart_pkg.sv
// Shared types and constants for the USART receive path.
package usart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int CNT_W      = $clog2(OVERSAMPLE);

   // Oversample ticks (pre-increment count) around the middle of a bit cell
   localparam logic [CNT_W-1:0] SMP_FIRST = CNT_W'(7);
   localparam logic [CNT_W-1:0] SMP_MID   = CNT_W'(8);
   localparam logic [CNT_W-1:0] SMP_LAST  = CNT_W'(9);

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b10,
      PAR_ODD  = 2'b11
   } parity_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2
   } rx_state_e;

   // The reserved encoding 01 behaves as "no parity"
   function automatic parity_mode_e par_decode(input logic [1:0] mode);
      case (mode)
         2'b10:   return PAR_EVEN;
         2'b11:   return PAR_ODD;
         default: return PAR_NONE;
      endcase
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/usart_rx_fifo.sv
// Small receive buffer; pointers carry an extra wrap bit to tell full from empty.
module usart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_pop;
   logic             w_do_push;

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // A pop in the same cycle frees the slot a push into a full buffer needs
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end

   assign dout = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/usart_rx.sv
// USART receiver: 16x oversampled, majority-voted bits, optional parity,
// one or two stop bits, small receive buffer with per-character error flags.
module usart_rx
   import usart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  baud_tick,
   input  logic                  rx_en,
   input  logic                  rxd,
   input  logic [1:0]            parity_mode,
   input  logic                  stop_bits,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  frame_err,
   output logic                  parity_err,
   output logic                  overrun,
   output logic                  rx_busy
);

   localparam int BCW = $clog2(DATA_WIDTH + 1);
   localparam int EW  = DATA_WIDTH + 2;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

   rx_state_e             r_state;
   rx_state_e             w_state_next;
   logic                  r_sync1;
   logic                  r_sync2;
   logic                  r_sync_q;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_smp_a;
   logic                  r_smp_b;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [BCW-1:0]        r_bitcnt;
   parity_mode_e          r_par_mode;
   logic                  r_two_stop;
   logic                  r_par_err;
   logic                  r_frm_err;
   logic                  r_overrun;
   logic                  w_start;
   logic                  w_decide;
   logic                  w_maj;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_frm_now;
   logic                  w_empty;
   logic                  w_full;
   logic [EW-1:0]         w_din;
   logic [EW-1:0]         w_dout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_sync_q <= 1'b1;
      end else begin
         r_sync1  <= rxd;
         r_sync2  <= r_sync1;
         r_sync_q <= r_sync2;
      end
   end

   assign w_start  = (r_state == ST_IDLE) && rx_en && r_sync_q && !r_sync2;
   assign w_decide = baud_tick && (r_cnt == SMP_LAST);
   assign w_maj    = maj3(r_smp_a, r_smp_b, r_sync2);

   always_ff @(posedge clk) begin
      if (rst)            r_cnt <= '0;
      else if (w_start)   r_cnt <= '0;
      else if (baud_tick) r_cnt <= r_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (baud_tick && r_cnt == SMP_FIRST) r_smp_a <= r_sync2;
      if (baud_tick && r_cnt == SMP_MID)   r_smp_b <= r_sync2;
      if (w_decide && r_state == ST_DATA)  r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_push       = 1'b0;
      w_frm_now    = r_frm_err;
      case (r_state)
         ST_IDLE:   if (w_start) w_state_next = ST_START;
         ST_START:  if (w_decide) w_state_next = w_maj ? ST_IDLE : ST_DATA;
         ST_DATA: begin
            if (w_decide && r_bitcnt == LAST_BIT)
               w_state_next = (r_par_mode == PAR_NONE) ? ST_STOP1 : ST_PARITY;
         end
         ST_PARITY: if (w_decide) w_state_next = ST_STOP1;
         ST_STOP1: begin
            if (w_decide) begin
               w_frm_now = ~w_maj;
               if (r_two_stop) begin
                  w_state_next = ST_STOP2;
               end else begin
                  w_push       = 1'b1;
                  w_state_next = ST_IDLE;
               end
            end
         end
         ST_STOP2: begin
            if (w_decide) begin
               w_frm_now    = r_frm_err | ~w_maj;
               w_push       = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default:   w_state_next = ST_IDLE;
      endcase
      // Disabling the receiver abandons any character in flight
      if (!rx_en) begin
         w_state_next = ST_IDLE;
         w_push       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bitcnt   <= '0;
         r_par_err  <= 1'b0;
         r_frm_err  <= 1'b0;
         r_par_mode <= PAR_NONE;
         r_two_stop <= 1'b0;
      end else if (w_start) begin
         r_bitcnt   <= '0;
         r_par_err  <= 1'b0;
         r_frm_err  <= 1'b0;
         r_par_mode <= par_decode(parity_mode);
         r_two_stop <= stop_bits;
      end else if (w_decide) begin
         case (r_state)
            ST_DATA:   r_bitcnt  <= r_bitcnt + BCW'(1);
            ST_PARITY: r_par_err <= (r_par_mode == PAR_ODD) ? ~(^r_shift ^ w_maj)
                                                           :  (^r_shift ^ w_maj);
            ST_STOP1:  r_frm_err <= ~w_maj;
            default:   ;
         endcase
      end
   end

   assign w_din = {r_shift, w_frm_now, r_par_err};
   assign w_pop = rd_en & ~w_empty;

   usart_rx_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_din),
      .dout  (w_dout),
      .empty (w_empty),
      .full  (w_full)
   );

   always_ff @(posedge clk) begin
      if (rst)                           r_overrun <= 1'b0;
      else if (w_pop)                    r_overrun <= 1'b0;
      else if (w_push && w_full)         r_overrun <= 1'b1;
   end

   // Buffer memory is not reset, so the head is masked while empty
   assign rx_valid   = ~w_empty;
   assign rx_data    = w_empty ? '0   : w_dout[EW-1:2];
   assign frame_err  = w_empty ? 1'b0 : w_dout[1];
   assign parity_err = w_empty ? 1'b0 : w_dout[0];
   assign overrun    = r_overrun;
   assign rx_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_usart_rx.sv
// Scoreboard bench for usart_rx: serial frames in, expected characters queued, popped on output.
module tb_usart_rx;

   localparam int BIT_CLKS = 64;   // 16 ticks of one baud_tick every 4 clocks

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_tick;
   logic       rx_en;
   logic       rxd;
   logic [1:0] parity_mode;
   logic       stop_bits;
   logic       rd_en;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       parity_err;
   logic       overrun;
   logic       rx_busy;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   tdiv  = 0;

   usart_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .baud_tick   (baud_tick),
      .rx_en       (rx_en),
      .rxd         (rxd),
      .parity_mode (parity_mode),
      .stop_bits   (stop_bits),
      .rd_en       (rd_en),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .frame_err   (frame_err),
      .parity_err  (parity_err),
      .overrun     (overrun),
      .rx_busy     (rx_busy)
   );

   always #5 clk = ~clk;

   initial begin
      baud_tick = 1'b0;
      forever begin
         @(negedge clk);
         tdiv      = (tdiv == 3) ? 0 : tdiv + 1;
         baud_tick = (tdiv == 0);
      end
   end

   initial begin
      #(700000 * 1ns);
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", tag, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      rxd = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pbit,
                             input int nstop, input logic stop2_val);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (has_par) send_bit(pbit);
      send_bit(1'b1);
      if (nstop == 2) send_bit(stop2_val);
      rxd = 1'b1;
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      while (!rx_valid && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (!rx_valid) begin
         check_eq({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      if (sb.size() == 0) begin
         check_eq({tag, "_unexpected"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check_eq({tag, "_data"}, rx_data, e.d);
         check_eq({tag, "_fe"}, frame_err, e.fe);
         check_eq({tag, "_pe"}, parity_err, e.pe);
      end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_valid"}, rx_valid, 1'b0);
      check_eq({tag, "_data"}, rx_data, 8'h00);
      check_eq({tag, "_fe"}, frame_err, 1'b0);
      check_eq({tag, "_pe"}, parity_err, 1'b0);
      check_eq({tag, "_ovr"}, overrun, 1'b0);
      check_eq({tag, "_busy"}, rx_busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; rx_en = 1'b0; rxd = 1'b1; parity_mode = 2'b00;
      stop_bits = 1'b0; rd_en = 1'b0;
      repeat (4) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      rx_en = 1'b1;
      idle_bits(1);

      // 8N1 0x5A with push-latency window on the stop bit
      sb.push_back('{d: 8'h5A, fe: 1'b0, pe: 1'b0});
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(8'h5A >> i);
      rxd = 1'b1;
      repeat (30) @(negedge clk);
      check_eq("lat_before", rx_valid, 1'b0);
      repeat (26) @(negedge clk);
      check_eq("lat_after", rx_valid, 1'b1);
      idle_bits(1);
      pop_check("n81_5a");
      idle_bits(1);

      // Parity: even with bad bit, even with good bit, odd with good bit
      parity_mode = 2'b10;
      sb.push_back('{d: 8'h03, fe: 1'b0, pe: 1'b1});
      send_frame(8'h03, 1'b1, 1'b1, 1, 1'b1);
      pop_check("e_bad");
      idle_bits(1);
      sb.push_back('{d: 8'h03, fe: 1'b0, pe: 1'b0});
      send_frame(8'h03, 1'b1, 1'b0, 1, 1'b1);
      pop_check("e_good");
      idle_bits(1);
      parity_mode = 2'b11;
      sb.push_back('{d: 8'h03, fe: 1'b0, pe: 1'b0});
      send_frame(8'h03, 1'b1, 1'b1, 1, 1'b1);
      pop_check("o_good");
      idle_bits(1);
      parity_mode = 2'b00;

      // Second stop bit low: framing error with 2 stop bits, a new start with 1
      stop_bits = 1'b1;
      sb.push_back('{d: 8'hFF, fe: 1'b1, pe: 1'b0});
      send_frame(8'hFF, 1'b0, 1'b0, 2, 1'b0);
      pop_check("n82_fe");
      idle_bits(2);
      check_eq("n82_no_restart", rx_valid, 1'b0);
      stop_bits = 1'b0;
      sb.push_back('{d: 8'hFF, fe: 1'b0, pe: 1'b0});
      sb.push_back('{d: 8'hFF, fe: 1'b0, pe: 1'b0});
      send_frame(8'hFF, 1'b0, 1'b0, 2, 1'b0);
      pop_check("n81_first");
      pop_check("n81_ghost");
      idle_bits(2);

      // False start: 5-tick low pulse
      rxd = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("fs_busy", rx_busy, 1'b1);
      idle_bits(1);
      check_eq("fs_idle", rx_busy, 1'b0);
      check_eq("fs_valid", rx_valid, 1'b0);

      // Overrun: third character is lost
      sb.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
      send_frame(8'h11, 1'b0, 1'b0, 1, 1'b1);
      idle_bits(1);
      sb.push_back('{d: 8'h22, fe: 1'b0, pe: 1'b0});
      send_frame(8'h22, 1'b0, 1'b0, 1, 1'b1);
      idle_bits(1);
      check_eq("ovr_pre", overrun, 1'b0);
      send_frame(8'h33, 1'b0, 1'b0, 1, 1'b1);
      idle_bits(1);
      check_eq("ovr_set", overrun, 1'b1);
      pop_check("ovr_11");
      check_eq("ovr_clr", overrun, 1'b0);
      pop_check("ovr_22");
      check_eq("ovr_empty", rx_valid, 1'b0);
      idle_bits(1);

      // rx_en dropped during data bit 3
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rxd = 1'b0;
      repeat (20) @(negedge clk);
      rx_en = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("en_drop_busy", rx_busy, 1'b0);
      repeat (BIT_CLKS - 23) @(negedge clk);
      for (int i = 0; i < 4; i++) send_bit(i[0]);
      idle_bits(2);
      rx_en = 1'b1;
      idle_bits(1);
      sb.push_back('{d: 8'hA5, fe: 1'b0, pe: 1'b0});
      send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1);
      pop_check("en_a5");
      idle_bits(1);
      check_eq("en_only_one", rx_valid, 1'b0);

      // Reset mid-frame with one character buffered
      send_frame(8'h77, 1'b0, 1'b0, 1, 1'b1);
      idle_bits(1);
      check_eq("rst_pre_valid", rx_valid, 1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rxd = 1'b0;
      repeat (30) @(negedge clk);
      check_eq("rst_pre_busy", rx_busy, 1'b1);
      rxd = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("rst_mid");
      idle_bits(12);
      check_eq("rst_nothing", rx_valid, 1'b0);

      check_eq("sb_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
